// File: rtl/subneg_mem_responder.sv
// -----------------------------------------------------------------------------
// subneg_mem_responder
//
// Memory-side responder for the SUBNEG core's external bus. It models the
// address latch, the SRAM and the output latch that sit behind the core's
// strobes. A host port preloads and reads back memory. Everything runs on the
// core clock. Strobes are treated as glitch-free levels synchronous to clk.
//
// Parameters:
//   DEPTH    : number of 8-bit words backed by storage (power of two, 2..256)
//   OUT_ADDR : address reserved for the output port, never backed by storage
//
// Ports:
//   clk, rst_n     : core clock, asynchronous active-low reset
//   mem_latch_clk  : address-latch strobe (level); a rise captures bus_in
//   mem_oe_n       : SRAM output enable, active low
//   mem_we_n       : SRAM write enable, active low; a fall commits one write
//   out_latch_clk  : output-latch strobe; a rise captures bus_in into out_data
//   bus_in         : data bus as driven by the core
//   bus_out        : read data toward the core (combinational, always computed)
//   bus_oe         : 1 = responder drives the bus
//   host_en        : 1 = host owns memory, core strobes ignored
//   host_we        : host write strobe, qualified by host_en
//   host_addr      : host address
//   host_wdata     : host write data
//   host_rdata     : host read data (combinational)
//   latched_addr   : current address-latch contents
//   out_data       : output latch contents
//   out_valid      : one-cycle pulse when out_data updates
//
// Optional build macro SUBNEG_RESP_STATS_EN adds:
//   rd_cnt         : saturating count of mem_oe_n falls while host_en=0
//   wr_cnt         : saturating count of accepted core writes (any address)
//   Both clear on a host write to OUT_ADDR.
// -----------------------------------------------------------------------------
module subneg_mem_responder #(
  parameter int DEPTH    = 32,
  parameter int OUT_ADDR = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mem_latch_clk,
  input  logic       mem_oe_n,
  input  logic       mem_we_n,
  input  logic       out_latch_clk,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic       host_en,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  output logic [7:0] latched_addr,
  output logic [7:0] out_data,
  output logic       out_valid
`ifdef SUBNEG_RESP_STATS_EN
  ,
  output logic [7:0] rd_cnt,
  output logic [7:0] wr_cnt
`endif
);

  localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] OUT_A = OUT_ADDR[7:0];

  // An address is backed only below DEPTH and never at the output port.
  function automatic logic addr_ok(input logic [7:0] a);
    return (int'(a) < DEPTH) && (a != OUT_A);
  endfunction

  logic [7:0] mem [DEPTH];

  // Edge history. These update every cycle regardless of host_en so that
  // handing the bus back to the core never produces a stale edge.
  logic latch_q;
  logic we_n_q;
  logic out_clk_q;

  logic latch_rise;
  logic we_fall;
  logic out_rise;

  assign latch_rise = ~latch_q & mem_latch_clk;
  assign we_fall    = we_n_q & ~mem_we_n;
  assign out_rise   = ~out_clk_q & out_latch_clk;

  // Write port shared by the core and the host; host_en selects the owner.
  logic          core_we_fall;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_data;

  assign core_we_fall = ~host_en & we_fall;
  assign wr_en   = host_en ? (host_we & addr_ok(host_addr))
                           : (we_fall & addr_ok(latched_addr));
  assign wr_idx  = host_en ? host_addr[AW-1:0] : latched_addr[AW-1:0];
  assign wr_data = host_en ? host_wdata : bus_in;

  // Read paths are combinational: the core samples the bus in the very cycle
  // it pulls OE low, so there is no room for a registered read.
  assign bus_oe     = ~mem_oe_n & ~host_en;
  assign bus_out    = addr_ok(latched_addr) ? mem[latched_addr[AW-1:0]] : 8'h00;
  assign host_rdata = addr_ok(host_addr) ? mem[host_addr[AW-1:0]] : 8'h00;

  // out_valid is a single-cycle strobe with no back-pressure: it is high for
  // exactly the one cycle after the capturing edge, and out_data holds the
  // captured byte from that cycle until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q      <= 1'b0;
      we_n_q       <= 1'b1;
      out_clk_q    <= 1'b0;
      latched_addr <= 8'h00;
      out_data     <= 8'h00;
      out_valid    <= 1'b0;
      mem          <= '{default: 8'h00};
    end else begin
      latch_q   <= mem_latch_clk;
      we_n_q    <= mem_we_n;
      out_clk_q <= out_latch_clk;
      out_valid <= 1'b0;

      // The write index is taken from the pre-update latched_addr, so a latch
      // rise in the same cycle as a WE fall does not redirect the write.
      if (wr_en) begin
        mem[wr_idx] <= wr_data;
      end

      if (!host_en) begin
        if (latch_rise) begin
          latched_addr <= bus_in;
        end
        if (out_rise) begin
          out_data  <= bus_in;
          out_valid <= 1'b1;
        end
      end
    end
  end

`ifdef SUBNEG_RESP_STATS_EN
  logic oe_n_q;
  logic rd_fall;
  logic stats_clr;

  assign rd_fall   = oe_n_q & ~mem_oe_n & ~host_en;
  assign stats_clr = host_en & host_we & (host_addr == OUT_A);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_n_q <= 1'b1;
      rd_cnt <= 8'h00;
      wr_cnt <= 8'h00;
    end else begin
      oe_n_q <= mem_oe_n;
      if (stats_clr) begin
        rd_cnt <= 8'h00;
        wr_cnt <= 8'h00;
      end else begin
        if (rd_fall && (rd_cnt != 8'hFF)) begin
          rd_cnt <= rd_cnt + 8'd1;
        end
        // Counts every accepted core write, including dropped out-of-range ones.
        if (core_we_fall && (wr_cnt != 8'hFF)) begin
          wr_cnt <= wr_cnt + 8'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_subneg_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_subneg_mem_responder
//
// Self-checking bench for subneg_mem_responder (DEPTH=32, OUT_ADDR=0xFF).
// Inputs change right after a falling clock edge; outputs are sampled at the
// falling edge or 1 ns after an input change, away from the rising edge.
// Read and output-port expectations go through queues filled when the
// stimulus is driven and drained when the DUT answers.
// Define SUBNEG_RESP_STATS_EN to also check rd_cnt / wr_cnt.
// -----------------------------------------------------------------------------
module tb_subneg_mem_responder;

  localparam int DEPTH = 32;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       mem_latch_clk;
  logic       mem_oe_n;
  logic       mem_we_n;
  logic       out_latch_clk;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       host_en;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic [7:0] latched_addr;
  logic [7:0] out_data;
  logic       out_valid;
`ifdef SUBNEG_RESP_STATS_EN
  logic [7:0] rd_cnt;
  logic [7:0] wr_cnt;
`endif

  subneg_mem_responder #(.DEPTH(DEPTH), .OUT_ADDR(255)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_latch_clk (mem_latch_clk),
    .mem_oe_n      (mem_oe_n),
    .mem_we_n      (mem_we_n),
    .out_latch_clk (out_latch_clk),
    .bus_in        (bus_in),
    .bus_out       (bus_out),
    .bus_oe        (bus_oe),
    .host_en       (host_en),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .latched_addr  (latched_addr),
    .out_data      (out_data),
    .out_valid     (out_valid)
`ifdef SUBNEG_RESP_STATS_EN
    ,
    .rd_cnt        (rd_cnt),
    .wr_cnt        (wr_cnt)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];      // expected bus_out for core reads
  logic [7:0] out_q[$];      // expected out_data captures
  logic [7:0] ref_mem [256];
  logic [7:0] model_lat;
  int         exp_rd;
  int         exp_wr;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
    end
  endtask

  function automatic logic model_ok(input logic [7:0] a);
    return (int'(a) < DEPTH) && (a != 8'hFF);
  endfunction

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    return model_ok(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    model_lat = 8'h00;
    exp_rd    = 0;
    exp_wr    = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef SUBNEG_RESP_STATS_EN
    check_val({tag, "_rd_cnt"}, rd_cnt, 8'((exp_rd > 255) ? 255 : exp_rd));
    check_val({tag, "_wr_cnt"}, wr_cnt, 8'((exp_wr > 255) ? 255 : exp_wr));
`else
    if (tag.len() == 0) $display("stats check needs a tag");
`endif
  endtask

  // Output-port monitor: every out_valid pulse must match a queued capture and
  // must not be preceded by another high cycle.
  logic last_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      check_val("out_pulse_len", 8'(last_ov), 8'h00);
      if (out_q.size() == 0) check_val("out_unexpected", 8'(out_valid), 8'h00);
      else                   check_val("out_data", out_data, out_q.pop_front());
    end
    last_ov = out_valid;
  end

  // ---------------------------------------------------------------- drivers
  // Every task starts just after a falling edge and returns just after one.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    step();
    host_we = 1'b0; host_en = 1'b0;
    if (model_ok(a)) ref_mem[a] = d;
    if (a == 8'hFF) begin exp_rd = 0; exp_wr = 0; end
  endtask

  task automatic latch_addr(input logic [7:0] a);
    bus_in = a; mem_latch_clk = 1'b1;
    step();
    mem_latch_clk = 1'b0;
    step();
    model_lat = a;
  endtask

  task automatic core_read(input string tag);
    mem_oe_n = 1'b0;
    exp_q.push_back(model_rd(model_lat));
    #1;
    check_val(tag, bus_out, exp_q.pop_front());
    check_val({tag, "_oe"}, 8'(bus_oe), 8'h01);
    step();
    mem_oe_n = 1'b1;
    exp_rd++;
    step();
  endtask

  task automatic core_write(input logic [7:0] d);
    bus_in = d; mem_we_n = 1'b0;
    step();
    mem_we_n = 1'b1;
    step();
    if (model_ok(model_lat)) ref_mem[model_lat] = d;
    exp_wr++;
  endtask

  task automatic check_mem_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      host_addr = 8'(i);
      #1;
      check_val(tag, host_rdata, ref_mem[i]);
    end
    step();
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- main
  logic [7:0] rd_addr [5];
  logic [7:0] result;
  logic [7:0] ra, rdv;
  int         k, ph;

  initial begin
    rst_n = 1'b0;
    mem_latch_clk = 1'b0; mem_oe_n = 1'b1; mem_we_n = 1'b1; out_latch_clk = 1'b0;
    bus_in = 8'h00; host_en = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
    model_reset();
    repeat (3) step();
    #1;
    check_val("rst_latched_addr", latched_addr, 8'h00);
    check_val("rst_out_data", out_data, 8'h00);
    check_val("rst_out_valid", 8'(out_valid), 8'h00);
    check_val("rst_bus_oe", 8'(bus_oe), 8'h00);
    check_val("rst_host_rdata", host_rdata, 8'h00);
    check_stats("rst");
    rst_n = 1'b1;
    step();

    // Host preload and readback through both ports.
    host_write(8'h03, 8'h5A);
    host_addr = 8'h03;
    #1 check_val("host_rd3", host_rdata, 8'h5A);
    host_en = 1'b1; mem_oe_n = 1'b0;
    #1 check_val("bus_oe_host", 8'(bus_oe), 8'h00);
    mem_oe_n = 1'b1; host_en = 1'b0;
    step();
    latch_addr(8'h03);
    #1 check_val("latched_3", latched_addr, 8'h03);
    core_read("core_rd3");

    // Write commit: one write per WE low pulse.
    latch_addr(8'h07);
    bus_in = 8'h21; mem_we_n = 1'b0;
    step(); step();
    bus_in = 8'h55;
    step();
    mem_we_n = 1'b1;
    step();
    ref_mem[7] = 8'h21; exp_wr++;
    host_addr = 8'h07;
    #1 check_val("wr_commit_mem7", host_rdata, 8'h21);
    check_stats("wr_commit");

    // Latch rise and WE fall together: write goes to the old address.
    bus_in = 8'h33; mem_latch_clk = 1'b1; mem_we_n = 1'b0;
    step();
    mem_latch_clk = 1'b0; mem_we_n = 1'b1;
    step();
    ref_mem[7] = 8'h33; model_lat = 8'h33; exp_wr++;
    host_addr = 8'h07;
    #1 check_val("simul_mem7", host_rdata, 8'h33);
    check_val("simul_latched", latched_addr, 8'h33);
    core_read("rd_oor_33");

    // Output port.
    latch_addr(8'hFF);
    bus_in = 8'hC4; out_latch_clk = 1'b1; out_q.push_back(8'hC4);
    step();
    out_latch_clk = 1'b0;
    step();
    #1 check_val("out_valid_drop", 8'(out_valid), 8'h00);
    check_val("out_data_hold", out_data, 8'hC4);
    core_read("rd_ff");

    // WE fall and output rise together.
    latch_addr(8'h09);
    bus_in = 8'h44; mem_we_n = 1'b0; out_latch_clk = 1'b1; out_q.push_back(8'h44);
    step();
    mem_we_n = 1'b1; out_latch_clk = 1'b0;
    step();
    ref_mem[9] = 8'h44; exp_wr++;
    host_addr = 8'h09;
    #1 check_val("we_out_mem9", host_rdata, 8'h44);

    // Out of range write is dropped, read returns zero.
    latch_addr(8'h40);
    core_write(8'h99);
    check_mem_all("oor_mem");
    core_read("rd_40");
    check_stats("oor");

    // Instruction replay: A=0x10, B=0x11, C=0x06; mem[B] <= mem[B]-mem[A].
    host_write(8'h00, 8'h10);
    host_write(8'h01, 8'h11);
    host_write(8'h02, 8'h06);
    host_write(8'h10, 8'h05);
    host_write(8'h11, 8'h03);
    rd_addr[0] = 8'h00; rd_addr[1] = 8'h01; rd_addr[2] = 8'h02;
    rd_addr[3] = ref_mem[0]; rd_addr[4] = ref_mem[1];
    result = ref_mem[ref_mem[1]] - ref_mem[ref_mem[0]];
    for (int s = 0; s < 25; s++) begin
      k  = s / 4;
      ph = s % 4;
      if (s < 20) begin
        case (ph)
          0: begin mem_oe_n = 1'b1; bus_in = rd_addr[k]; end
          1: begin mem_latch_clk = 1'b1; model_lat = rd_addr[k]; end
          2: mem_latch_clk = 1'b0;
          default: begin
            mem_oe_n = 1'b0;
            exp_q.push_back(model_rd(model_lat));
            exp_rd++;
            #1 check_val($sformatf("replay_rd%0d", k), bus_out, exp_q.pop_front());
          end
        endcase
      end else begin
        case (s)
          20: begin mem_oe_n = 1'b1; bus_in = rd_addr[4]; end
          21: begin mem_latch_clk = 1'b1; model_lat = rd_addr[4]; end
          22: begin mem_latch_clk = 1'b0; bus_in = result; end
          23: mem_we_n = 1'b0;
          default: mem_we_n = 1'b1;
        endcase
      end
      step();
    end
    ref_mem[rd_addr[4]] = result; exp_wr++;
    host_addr = 8'h11;
    #1 check_val("replay_mem11", host_rdata, 8'hFE);
    check_stats("replay");

    // Host ownership: strobes under host_en cause nothing, release adds no edge.
    host_en = 1'b1; mem_latch_clk = 1'b1; bus_in = 8'h0A;
    step();
    mem_we_n = 1'b0; out_latch_clk = 1'b1;
    step();
    host_en = 1'b0;
    step();
    mem_latch_clk = 1'b0; mem_we_n = 1'b1; out_latch_clk = 1'b0;
    step();
    #1 check_val("host_no_capture", latched_addr, model_lat);
    check_mem_all("host_no_write");

    // Host write to the output address clears the counters.
    host_write(8'hFF, 8'hAB);
    host_addr = 8'hFF;
    #1 check_val("host_rd_ff", host_rdata, 8'h00);
    check_stats("stats_clr");

    // Random traffic across in-range and unbacked addresses.
    for (int i = 0; i < 8; i++) begin
      ra  = 8'($urandom_range(0, 47));
      rdv = 8'($urandom_range(0, 255));
      latch_addr(ra);
      core_write(rdv);
      core_read($sformatf("rand_rd%0d", i));
    end
    check_stats("rand");

    // Reset pulse during a WE-low window.
    latch_addr(8'h05);
    bus_in = 8'h66; mem_we_n = 1'b0;
    step();
    rst_n = 1'b0;
    #1 check_val("rst_async_latched", latched_addr, 8'h00);
    model_reset();
    step();
    mem_we_n = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    check_mem_all("rst_mid_mem");
    #1 check_val("rst_mid_latched", latched_addr, 8'h00);
    check_stats("rst_mid");

    step(); step();
    check_val("out_q_drain", 8'(out_q.size()), 8'h00);
    check_val("exp_q_drain", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/subneg_mem_responder.md
Name: subneg_mem_responder

Overview:
- Memory-side responder for the SUBNEG core's external bus; stands in for the address latch, SRAM and output latch on the far end of the strobes.
- Captures addresses on latch-clock rising edges and drives read data while OE is low.
- Commits writes on WE falling edges and captures the output byte on out-latch rising edges.
- Provides a host port for program preload and readback. All logic is on the core's clock.

Parameters:
- DEPTH, 32, number of 8-bit words implemented (power of two, 2..256); addresses DEPTH..255 are unbacked.
- OUT_ADDR, 255, address reserved as the output port; never backed by storage.

Ports:
- clk  in  1  clock, shared with the core
- rst_n  in  1  asynchronous active-low reset
- mem_latch_clk  in  1  address-latch strobe from the core, level
- mem_oe_n  in  1  SRAM output enable from the core, active low
- mem_we_n  in  1  SRAM write enable from the core, active low
- out_latch_clk  in  1  output-latch strobe from the core
- bus_in  in  8  shared data bus as driven by the core
- bus_out  out  8  read data toward the core
- bus_oe  out  1  1 = responder drives the bus
- host_en  in  1  1 = host owns memory; core strobes ignored
- host_we  in  1  host write strobe, qualified by host_en
- host_addr  in  8  host address
- host_wdata  in  8  host write data
- host_rdata  out  8  host read data, combinational
- latched_addr  out  8  current address-latch contents
- out_data  out  8  output latch contents
- out_valid  out  1  one-cycle pulse when out_data updates

Behaviour:
- Reset (async, rst_n=0):
  - latched_addr=0x00, out_data=0x00, out_valid=0, every memory word=0x00.
  - Edge history registers go to idle levels: latch=0, we_n=1, out_clk=0.
- Edge detection: registered copies of mem_latch_clk, mem_we_n and out_latch_clk are compared with current inputs.
  - The history registers update every cycle, including while host_en=1, so releasing host_en never creates a false edge.
- Address capture: on a latch rise (prev=0, now=1) with host_en=0, latched_addr <= bus_in at that clock edge. The core latches in its state 1, so the address is valid from its state 3 onward.
- Read path is fully combinational, because the core samples the bus in the same cycle OE is low:
  - bus_oe = ~mem_oe_n & ~host_en.
  - bus_out = mem[latched_addr] if latched_addr < DEPTH; otherwise 0x00, which includes OUT_ADDR.
  - bus_out is always computed, even when bus_oe=0.
- Write: on a WE fall (prev=1, now=0) with host_en=0, mem[latched_addr] <= bus_in.
  - Writes to addresses >= DEPTH are dropped.
  - Exactly one write per low pulse, however long WE stays low.
- Output latch: on an out_latch_clk rise with host_en=0, out_data <= bus_in and out_valid=1 for that one cycle; otherwise out_valid=0.
- Simultaneous events:
  - Latch rise and WE fall in the same cycle: the write uses the pre-update latched_addr.
  - WE fall and out-latch rise together: both take effect.
- Host port:
  - host_rdata = mem[host_addr] when host_addr < DEPTH, else 0x00.
  - host_en & host_we writes host_wdata at the clock edge; out-of-range host writes are dropped.
  - While host_en=1, core strobes cause no capture, write or output.
- Reset mid-operation: all state and memory clear at once. The core must reload through the host port.
- Strobes are assumed glitch-free and synchronous to clk. No metastability hardening.

Optional Feature:
- Macro: SUBNEG_RESP_STATS_EN.
- Defined:
  - Adds outputs rd_cnt[7:0] and wr_cnt[7:0], reset to 0.
  - rd_cnt increments on each mem_oe_n falling edge with host_en=0.
  - wr_cnt increments on each accepted core write, in range or not.
  - Both saturate at 0xFF.
  - Both are cleared by host_en & host_we & (host_addr==OUT_ADDR).
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Host preload then readback: host writes mem[3]=0x5A with host_en=1 -> host_rdata=0x5A at host_addr=3. With host_en=0, bus_in=0x03, latch 0->1, then mem_oe_n=0 -> latched_addr=0x03, bus_oe=1, bus_out=0x5A in the same cycle.
- Write commit: latch addr 0x07; bus_in=0x21; mem_we_n low for 3 cycles -> mem[7]=0x21, exactly one write (wr_cnt=1 with SUBNEG_RESP_STATS_EN). A later bus_in change while WE stays low does not alter mem[7].
- Output port: latch 0xFF; bus_in=0xC4; out_latch_clk rise -> out_data=0xC4, out_valid high for exactly 1 cycle. A read of 0xFF returns 0x00.
- Out of range with DEPTH=32: latch 0x40, write 0x99 -> no memory word changes, and a read of 0x40 gives 0x00.
- Full core instruction replay: program [0x10,0x11,0x06] with mem[0x10]=5 and mem[0x11]=3, driven by a cycle-accurate strobe model of states 0..24 -> bus reads return 0x10, 0x11, 0x06, 5, 3, and mem[0x11]=0xFE after state 24.
- Host/reset interaction:
  - Assert host_en while mem_latch_clk=1, then release -> no capture.
  - Pulse rst_n low during a WE-low window -> memory all 0x00, latched_addr=0, no write after release.
